// File: rtl/vending_pkg.sv
// Shared types and constants for the vending front end: coin codes,
// denomination values, acceptor FSM states and the credit width/limit.
package vending_pkg;

    // Width of every credit/price quantity exchanged with the controller.
    localparam int CREDIT_W = 4;

    // Largest credit a session may hold; the controller's total is CREDIT_W bits wide.
    localparam int MAX_CREDIT_DEFAULT = 15;

    // Raw denomination code reported by the coin mechanism.
    typedef enum logic [1:0] {
        COIN_1   = 2'b00,
        COIN_2   = 2'b01,
        COIN_5   = 2'b10,
        COIN_BAD = 2'b11
    } coin_code_t;

    // Denomination values in credit units.
    localparam logic [CREDIT_W-1:0] VALUE_COIN_1 = 4'd1;
    localparam logic [CREDIT_W-1:0] VALUE_COIN_2 = 4'd2;
    localparam logic [CREDIT_W-1:0] VALUE_COIN_5 = 4'd5;

    // Debounce / qualification FSM of the coin acceptor.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_RELEASE = 2'd2
    } acc_state_t;

    // Credit value of a code; the invalid code maps to zero and is rejected upstream.
    function automatic logic [CREDIT_W-1:0] coin_value_of(input coin_code_t code);
        logic [CREDIT_W-1:0] value;
        case (code)
            COIN_1:  value = VALUE_COIN_1;
            COIN_2:  value = VALUE_COIN_2;
            COIN_5:  value = VALUE_COIN_5;
            default: value = '0;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/coin_fifo.sv
// Small synchronous FIFO holding accepted coin values until the controller
// is idle. Full/empty are registered flags; the head is read straight from
// the storage array so a pop can capture it in the same cycle.
module coin_fifo #(
    parameter int DEPTH = 4,   // power of two, at least 2
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is only taken when a pop frees the slot in the same cycle.
    assign do_pop  = pop && !empty_reg;
    assign do_push = push && (!full_reg || do_pop);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_next = count_reg - (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_CNT);
            empty_reg <= (count_next == '0);
        end
    end

    assign full  = full_reg;
    assign empty = empty_reg;
    assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces the coin sensor,
// classifies each physical coin once, rejects invalid / over-limit / no-room
// coins, buffers accepted coins and hands them to the controller one at a
// time while it reports idle. Tracks session credit so the controller's
// 4-bit total cannot overflow.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,                  // 2..15
    parameter int FIFO_DEPTH      = 4,                  // power of two
    parameter int MAX_CREDIT      = MAX_CREDIT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sensor_det,
    input  logic [1:0]          sensor_code,
    input  logic                accept_ready,
    input  logic                credit_clear,
    output logic                coin_in,
    output logic [CREDIT_W-1:0] coin_value,
    output logic                coin_reject,
    output logic                fifo_full,
    output logic [CREDIT_W-1:0] session_sum
);

    localparam logic [3:0]          D_CNT   = 4'(DEBOUNCE_CYCLES);
    localparam logic [3:0]          D_LAST  = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [CREDIT_W:0]   MAX_EXT = (CREDIT_W+1)'(MAX_CREDIT);

    // ------------------------------------------------------------------
    // Two-flop synchronisers for det and both code bits
    // ------------------------------------------------------------------
    logic [2:0] raw_bits;
    logic [2:0] sync_bits;

    assign raw_bits = {sensor_code, sensor_det};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        logic s1_reg;
        logic s2_reg;

        // Two-stage metastability filter for one raw sensor bit.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1_reg <= 1'b0;
                s2_reg <= 1'b0;
            end else begin
                s1_reg <= raw_bits[gi];
                s2_reg <= s1_reg;
            end
        end

        assign sync_bits[gi] = s2_reg;
    end

    logic       det_s;
    coin_code_t code_s;

    assign det_s  = sync_bits[0];
    assign code_s = coin_code_t'(sync_bits[2:1]);

    // ------------------------------------------------------------------
    // Debounce FSM state
    // ------------------------------------------------------------------
    acc_state_t state_reg;
    logic [3:0] cnt_reg;
    coin_code_t cap_code_reg;

    // ------------------------------------------------------------------
    // Classifier and issue decisions (all from registered state)
    // ------------------------------------------------------------------
    logic                classify_fire;
    logic [CREDIT_W-1:0] cls_value;
    logic [CREDIT_W:0]   sum_ext;
    logic                over_limit;
    logic                reject_now;
    logic                accept_now;
    logic                pop_now;

    logic                fifo_full_w;
    logic                fifo_empty_w;
    logic [CREDIT_W-1:0] fifo_head_w;

    logic                coin_in_reg;
    logic [CREDIT_W-1:0] coin_value_reg;
    logic                coin_reject_reg;
    logic [CREDIT_W-1:0] session_sum_reg;

    // The classify cycle is the QUAL cycle in which the count reaches the
    // threshold while det and the captured code are still intact.
    assign classify_fire = (state_reg == ST_QUAL) && det_s &&
                           (code_s == cap_code_reg) && (cnt_reg == D_CNT);

    assign cls_value  = coin_value_of(cap_code_reg);
    assign sum_ext    = {1'b0, session_sum_reg} + {1'b0, cls_value};
    assign over_limit = (sum_ext > MAX_EXT);

    // A coin is only issued when the previous event cycle has ended, which
    // leaves at least one idle cycle between consecutive events.
    assign pop_now = !fifo_empty_w && accept_ready && !coin_in_reg;

    // Rejects in priority order: invalid code, credit limit, no buffer room.
    assign reject_now = classify_fire &&
                        ((cap_code_reg == COIN_BAD) || over_limit ||
                         (fifo_full_w && !pop_now));
    assign accept_now = classify_fire && !reject_now;

    // Debounce FSM: qualify insertion for DEBOUNCE_CYCLES, classify once,
    // then wait for DEBOUNCE_CYCLES consecutive det-low cycles before re-arming.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            cap_code_reg <= COIN_1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (det_s) begin
                        state_reg    <= ST_QUAL;
                        cap_code_reg <= code_s;
                        cnt_reg      <= 4'd1;
                    end
                end
                ST_QUAL: begin
                    if (!det_s || (code_s != cap_code_reg)) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == D_CNT) begin
                        state_reg <= ST_RELEASE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                ST_RELEASE: begin
                    // cnt holds the number of det-low cycles already seen;
                    // the DEBOUNCE_CYCLES-th one re-arms the FSM.
                    if (det_s) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == D_LAST) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // Reject pulse, high for the cycle after classification.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coin_reject_reg <= 1'b0;
        end else begin
            coin_reject_reg <= reject_now;
        end
    end

    // Session credit; a clear coinciding with an accept keeps only the new coin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            session_sum_reg <= '0;
        end else if (accept_now) begin
            session_sum_reg <= credit_clear ? cls_value : (session_sum_reg + cls_value);
        end else if (credit_clear) begin
            session_sum_reg <= '0;
        end
    end

    // Issue: the popped head becomes a single-cycle coin event on the next edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coin_in_reg    <= 1'b0;
            coin_value_reg <= '0;
        end else begin
            coin_in_reg    <= pop_now;
            coin_value_reg <= pop_now ? fifo_head_w : '0;
        end
    end

    coin_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CREDIT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept_now),
        .wdata (cls_value),
        .pop   (pop_now),
        .full  (fifo_full_w),
        .empty (fifo_empty_w),
        .head  (fifo_head_w)
    );

    assign coin_in     = coin_in_reg;
    assign coin_value  = coin_value_reg;
    assign coin_reject = coin_reject_reg;
    assign fifo_full   = fifo_full_w;
    assign session_sum = session_sum_reg;

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

- Front-end stage directly upstream of the vending controller.
- Synchronizes and debounces the raw coin-mechanism sensor, classifies the denomination, and rejects invalid or over-limit coins.
- Buffers accepted coins in a small FIFO and presents them to the controller as single-cycle `coin_in` / `coin_value` events, only while the controller reports it is idle.
- Tracks session credit so the controller's 4-bit running total can never overflow.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 8: consecutive stable cycles required to qualify insertion and release (range 2–15).
- `FIFO_DEPTH`, default 4: accepted-coin buffer entries (power of two).
- `MAX_CREDIT`, default 15: maximum session credit.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `sensor_det` in 1: raw coin-present signal, asynchronous to `clk`.
- `sensor_code` in 2: raw denomination code; stable whenever `sensor_det` is stable.
- `accept_ready` in 1: controller idle, i.e. able to take a coin this cycle.
- `credit_clear` in 1: single-cycle pulse from the controller at end of transaction (dispense or refund).
- `coin_in` out 1: single-cycle coin event to the controller.
- `coin_value` out 4: value of the coin; 0 whenever `coin_in` = 0.
- `coin_reject` out 1: single-cycle pulse; the coin is routed to the return chute.
- `fifo_full` out 1: buffer holds `FIFO_DEPTH` entries.
- `session_sum` out 4: credit accepted since the last `credit_clear`.

## Operation

- **Synchronizer:** 2-flop synchronizer on `sensor_det` and on both `sensor_code` bits. All downstream logic uses only the synchronized copies.
- **Code map:** 00 → 1, 01 → 2, 10 → 5, 11 → invalid.
- **FSM states:** IDLE, QUAL, RELEASE.
  - **IDLE:** synced det = 1 → QUAL; capture code; cnt = 1.
  - **QUAL:**
    - det = 0, or code ≠ captured → IDLE with no event (glitch).
    - Otherwise, if cnt = `DEBOUNCE_CYCLES`, classify this cycle and go to RELEASE.
    - Otherwise cnt++.
  - **RELEASE:** cnt counts consecutive det = 0 cycles. Any det = 1 restarts cnt at 0. cnt = `DEBOUNCE_CYCLES` → IDLE. This guarantees one event per physical coin.
- **Classify (single cycle), rejects in priority order:**
  1. Code 11.
  2. `session_sum` + value > `MAX_CREDIT`, evaluated at 5-bit width.
  3. FIFO full with no pop in the same cycle.
- **Classify, accept:** push value into the FIFO and set `session_sum` += value.
- **Issue:** FIFO non-empty AND `accept_ready` = 1 AND `coin_in` currently 0 → pop the head, and on the next edge drive `coin_in` = 1 with `coin_value` = head. Issued coins are therefore separated by at least one idle cycle.
- **`credit_clear`:**
  - Sets `session_sum` to 0.
  - If an accept happens in the same cycle, `session_sum` = that coin's value.
  - Does not flush the FIFO.
- **Simultaneous push and pop:** allowed when the FIFO is full; the push is accepted.
- **Reset** (asserted at any time, including mid-qualification):
  - FSM to IDLE, cnt 0, FIFO emptied, sync flops 0.
  - `coin_in`, `coin_value`, `coin_reject`, `fifo_full`, `session_sum` all 0.
  - A coin that was mid-qualification is discarded with no reject pulse.

## Timing

- Edge E0 is the first rising edge at which raw `sensor_det` = 1 is sampled; D = `DEBOUNCE_CYCLES`.
- E2: FSM enters QUAL.
- E(D+2): classify. `coin_reject` is high for the following cycle if rejected; otherwise the coin is pushed.
- E(D+3): `coin_in` is high (empty FIFO, `accept_ready` = 1). Minimum insertion-to-event latency is D+3 cycles.
- `accept_ready` low: the head is held indefinitely with no loss. `coin_in` asserts on the edge after the first cycle with `accept_ready` = 1.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure

- `vending_pkg` holds:
  - The coin-code enum (`COIN_1`, `COIN_2`, `COIN_5`, `COIN_BAD`) and the denomination value constants.
  - The acceptor FSM state typedef.
  - The `MAX_CREDIT` default, shared with the controller's price/total width.
- Sub-module `coin_fifo`:
  - Synchronous, `FIFO_DEPTH` × 4 bits.
  - Push, pop, full, empty, head.
  - Same asynchronous active-low reset.
- Top level holds the synchronizer, debounce FSM, classifier, credit counter, and issue logic.

## Test plan

1. Clean 5-coin: code 10 held 20 cycles, `accept_ready` = 1 → `coin_in` for one cycle at E(D+3) with `coin_value` = 5; `session_sum` = 5; no reject.
2. Glitch: `sensor_det` high for D−2 cycles, then low → no `coin_in`, no `coin_reject`; FSM returns to IDLE.
3. Over-limit: accept 5, 5, 2 (sum 12), then insert 5 → `coin_reject` pulse; `session_sum` stays 12. Then `credit_clear` and insert 5 → accepted, sum 5.
4. Buffering: `accept_ready` = 0; insert 1, 2, 5, 1, then 2 → fifth coin rejected, `fifo_full` = 1. Raise `accept_ready` → `coin_in` events with values 1, 2, 5, 1, at least one cycle apart.
5. Invalid code 11 held 20 cycles → exactly one `coin_reject`, no FIFO change. A bouncing release (det 0/1 alternating) → no second event.
6. Reset asserted mid-QUAL and with the FIFO holding 2 coins → all outputs 0 immediately; after release, no stale `coin_in`.
